// File: rtl/fir_coef_store.sv
// fir_coef_store: run-time loadable signed-magnitude coefficient store that
// streams one NTAPS-word tap set per start over a valid/ready handshake.
// Optional macro FIR_COEF_SYMMETRIC_EN: linear-phase mode, NTAPS/2 stored
// words per set with the second half of the burst read back mirrored.
module fir_coef_store #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NTAPS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic [AW-1:0] base,
  output logic [DW-1:0] coef_data,
  output logic          coef_valid,
  input  logic          coef_ready,
  output logic          coef_last,
  output logic          busy,
  output logic          start_err
);

  localparam int unsigned TW   = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned HALF = NTAPS / 2;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tap_q, tap_d;
  logic [AW-1:0]     base_q, base_d;
  logic [DW-1:0]     coef_data_q, coef_data_d;
  logic              coef_valid_q, coef_valid_d;
  logic              coef_last_q, coef_last_d;
  logic              busy_q, busy_d;
  logic              start_err_q, start_err_d;
  logic [DEPTH-1:0]  written_q, written_d;
  logic [DW-1:0]     mem_q [DEPTH];

  logic [TW-1:0]     fetch_tap_c;
  logic [TW-1:0]     fetch_off_c;
  logic [AW-1:0]     fetch_addr_c;
  logic [DW-1:0]     rd_data_c;
  logic              last_tap_c;

  // Fetch address: in HOLD the next tap is fetched on the transfer edge.
  always_comb begin
    fetch_tap_c = (state_q == ST_HOLD) ? (tap_q + TW'(1)) : tap_q;
`ifdef FIR_COEF_SYMMETRIC_EN
    fetch_off_c = (fetch_tap_c < TW'(HALF)) ? fetch_tap_c
                                            : (TW'(NTAPS - 1) - fetch_tap_c);
`else
    fetch_off_c = fetch_tap_c;
`endif
    fetch_addr_c = base_q + AW'(fetch_off_c);
    rd_data_c    = written_q[fetch_addr_c] ? mem_q[fetch_addr_c] : '0;
    last_tap_c   = (fetch_tap_c == TW'(NTAPS - 1));
  end

  // Written flags: a never-written word reads as zero.
  always_comb begin
    written_d = written_q;
    if (wr_en) begin
      written_d[wr_addr] = 1'b1;
    end
  end

  // Coefficient array; not reset, the written flags mask stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Burst FSM next-state and output logic.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    base_d       = base_q;
    coef_data_d  = coef_data_q;
    coef_valid_d = coef_valid_q;
    coef_last_d  = coef_last_q;
    busy_d       = busy_q;
    start_err_d  = start && cs && busy_q;

    case (state_q)
      ST_IDLE: begin
        if (start && cs) begin
          base_d  = base;
          tap_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (cs) begin
          coef_data_d  = rd_data_c;
          coef_valid_d = 1'b1;
          coef_last_d  = last_tap_c;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (coef_valid_q && coef_ready) begin
          if (coef_last_q) begin
            coef_valid_d = 1'b0;
            coef_last_d  = 1'b0;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            tap_d = tap_q + TW'(1);
            if (cs) begin
              coef_data_d  = rd_data_c;
              coef_valid_d = 1'b1;
              coef_last_d  = last_tap_c;
            end else begin
              coef_valid_d = 1'b0;
              coef_last_d  = 1'b0;
              state_d      = ST_FETCH;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      base_q       <= '0;
      coef_data_q  <= '0;
      coef_valid_q <= 1'b0;
      coef_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      start_err_q  <= 1'b0;
      written_q    <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      base_q       <= base_d;
      coef_data_q  <= coef_data_d;
      coef_valid_q <= coef_valid_d;
      coef_last_q  <= coef_last_d;
      busy_q       <= busy_d;
      start_err_q  <= start_err_d;
      written_q    <= written_d;
    end
  end

  assign coef_data  = coef_data_q;
  assign coef_valid = coef_valid_q;
  assign coef_last  = coef_last_q;
  assign busy       = busy_q;
  assign start_err  = start_err_q;

endmodule

// File: tb/tb_fir_coef_store.sv
// Scoreboard bench for fir_coef_store: the stimulus process queues expected
// words, a negedge monitor pops and compares on every handshake transfer.
module tb_fir_coef_store;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NT    = 16;
`ifdef FIR_COEF_SYMMETRIC_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [AW-1:0] base;
  logic [DW-1:0] coef_data;
  logic          coef_valid;
  logic          coef_ready;
  logic          coef_last;
  logic          busy;
  logic          start_err;

  fir_coef_store #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NTAPS(NT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .base       (base),
    .coef_data  (coef_data),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_last  (coef_last),
    .busy       (busy),
    .start_err  (start_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            errors   = 0;
  int            checks   = 0;
  int            xfer_cnt = 0;
  logic [DW-1:0] mmem [DEPTH];
  bit            mwr  [DEPTH];
  bit            hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_val(input logic [AW-1:0] b, input int t);
    int            off;
    logic [AW-1:0] a;
    off = (SYM && t >= NT / 2) ? (NT - 1 - t) : t;
    a   = b + AW'(off);
    return mwr[a] ? mmem[a] : '0;
  endfunction

  // Monitor: hold stability while stalled, and scoreboard pop on transfer.
  always @(negedge clk) begin
    if (rst_n && hold_pend && coef_valid) begin
      check("hold_data", 32'(coef_data), 32'(hold_data));
      check("hold_last", 32'(coef_last), 32'(hold_last));
    end
    hold_pend = coef_valid && !coef_ready;
    hold_data = coef_data;
    hold_last = coef_last;
    if (rst_n && coef_valid && coef_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", coef_data);
      end else begin
        mon_e = sb.pop_front();
        check("coef_data", 32'(coef_data), 32'(mon_e.data));
        check("coef_last", 32'(coef_last), 32'(mon_e.last));
        xfer_cnt++;
      end
    end
  end

  task automatic write_word(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    mmem[a] = DW'(d);
    mwr[a]  = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // mode 0: ready high; 1: ready 1,0,0 pattern; 2: cs dropped 3 cycles;
  // 3: start while busy and on the last-tap transfer.
  task automatic run_burst(input logic [AW-1:0] b, input int mode);
    exp_t e;
    int   ncyc;
    xfer_cnt = 0;
    for (int t = 0; t < NT; t++) begin
      e.data = exp_val(b, t);
      e.last = (t == NT - 1);
      sb.push_back(e);
    end
    base  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_valid", 32'(coef_valid), 32'd0);
    check("start_err_accept", 32'(start_err), 32'd0);
    ncyc = 0;
    for (int c = 0; c < 400; c++) begin
      if (!busy) break;
      coef_ready = (mode == 1) ? ((c % 3) == 0) : 1'b1;
      cs         = !(mode == 2 && c >= 5 && c <= 7);
      start      = (mode == 3 && (c == 4 || c == 16));
      @(posedge clk); #1;
      start = 1'b0;
      ncyc++;
      if (c == 0) check("first_valid", 32'(coef_valid), 32'd1);
      if (mode == 2 && c >= 5 && c <= 7) check("cs_drop_valid", 32'(coef_valid), 32'd0);
      if (mode == 3 && (c == 4 || c == 16)) check("start_err_busy", 32'(start_err), 32'd1);
      if (mode == 3 && c == 5) check("start_err_pulse", 32'(start_err), 32'd0);
    end
    cs         = 1'b1;
    coef_ready = 1'b1;
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: busy still %0d expected 0", busy);
    end else begin
      check("xfer_count", 32'(xfer_cnt), 32'(NT));
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("end_valid", 32'(coef_valid), 32'd0);
      if (mode == 0 || mode == 3) check("burst_cycles", 32'(ncyc), 32'(NT + 1));
    end
    sb.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_data"},  32'(coef_data),  32'd0);
    check({tag, "_valid"}, 32'(coef_valid), 32'd0);
    check({tag, "_last"},  32'(coef_last),  32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_err"},   32'(start_err),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    cs         = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    start      = 1'b0;
    base       = '0;
    coef_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      mmem[i] = '0;
      mwr[i]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_burst(AW'(0), 0);

    for (int k = 0; k < DEPTH; k++) write_word(k, k + 1);

    run_burst(AW'(0), 0);
    run_burst(AW'(24), 0);
    run_burst(AW'(0), 1);
    run_burst(AW'(0), 3);
    run_burst(AW'(0), 2);

    // start without cs is silently ignored
    cs    = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("nocs_busy", 32'(busy), 32'd0);
    check("nocs_err", 32'(start_err), 32'd0);
    cs = 1'b1;
    @(posedge clk); #1;

    // asynchronous reset in the middle of a stalled burst
    coef_ready = 1'b0;
    base       = '0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_valid", 32'(coef_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outs("midreset");
    for (int i = 0; i < DEPTH; i++) mwr[i] = 1'b0;
    @(posedge clk); #1;
    rst_n      = 1'b1;
    coef_ready = 1'b1;
    @(posedge clk); #1;

    run_burst(AW'(0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_coef_store.md
Name: fir_coef_store

Overview:
- Parametrised coefficient store for the FIR datapath. It replaces the fixed 32x8 coefficient table and the per-read chip-select access.
- Coefficients are signed-magnitude, DW bits wide (MSB = sign). They are loaded at run time through a write port.
- On a start pulse, the block streams one full tap set (NTAPS words) to the MAC stage over a valid/ready handshake, and marks the final tap with a last flag.

Parameters:
DW, 8, coefficient width (sign bit + DW-1 magnitude bits)
DEPTH, 32, number of stored words
AW, 5, address width; must satisfy 2**AW == DEPTH
NTAPS, 16, words per burst; must be even and <= DEPTH

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cs  in  1  block enable; gates start and fetches
wr_en  in  1  coefficient write strobe
wr_addr  in  AW  write address
wr_data  in  DW  write data
start  in  1  single-cycle burst request
base  in  AW  burst start address, sampled on accepted start
coef_data  out  DW  streamed coefficient
coef_valid  out  1  coef_data is valid
coef_ready  in  1  MAC stage accepts coef_data
coef_last  out  1  marks tap NTAPS-1 of the burst
busy  out  1  burst in progress
start_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (rst_n low, async):
  - coef_data=0, coef_valid=0, coef_last=0, busy=0, start_err=0.
  - FSM goes to IDLE; tap counter=0.
  - All per-word written flags clear. Memory array itself is not reset.
- Storage:
  - A word whose written flag is 0 reads as 0.
  - When wr_en is high at a clock edge, mem[wr_addr] <= wr_data and its written flag is set. This happens independent of cs and of FSM state.
  - Write and fetch to the same address in the same cycle: the fetch returns the old data (read-first).
- FSM states: IDLE, FETCH, HOLD.
- IDLE:
  - start & cs accepted: latch base, tap=0, busy=1, go to FETCH.
  - start & !cs: ignored, no error.
- FETCH (one cycle):
  - Register mem[addr] into coef_data; coef_valid=1; coef_last=(tap==NTAPS-1); go to HOLD.
  - addr = (base + tap) mod DEPTH, so addresses wrap past DEPTH-1 to 0.
- HOLD:
  - coef_data, coef_valid and coef_last are held stable while !coef_ready.
  - On coef_valid & coef_ready:
    - Last tap: coef_valid=0, busy=0, go to IDLE.
    - Otherwise, cs=1: tap+1, fetch the next word on the same edge, coef_valid stays 1, stay in HOLD. This gives full throughput of one word per cycle.
    - Otherwise, cs=0: tap+1, coef_valid=0, go to FETCH. FETCH stalls with no fetch until cs=1.
- Latency: start at edge N gives first coef_valid after edge N+1. With ready held high, a burst occupies exactly NTAPS consecutive valid cycles, and busy falls after the edge that transfers the last tap.
- start while busy: ignored; start_err=1 for one cycle.
- start arriving in the same cycle as the last-tap transfer: rejected with start_err. The requester retries next cycle.
- Reset mid-burst: all outputs return to their reset values immediately.

Optional Feature:
- Macro: FIR_COEF_SYMMETRIC_EN.
- Defined (linear-phase mode): only NTAPS/2 words are stored per set.
  - Tap t in 0..NTAPS/2-1 reads base+t.
  - Tap t in NTAPS/2..NTAPS-1 reads base+(NTAPS-1-t).
  - Wrap remains mod DEPTH. Burst length and handshake are unchanged.
- Undefined: linear addressing only; no mirror logic is present.

Test Plan:
- Reset, then a burst at base=0 with ready=1, no writes -> 16 valid cycles, all coef_data=0, coef_last only on the 16th, busy low afterwards.
- Write mem[k]=k+1 for k=0..31; start base=0, ready=1 -> coef_data 1..16 on consecutive cycles; first valid one cycle after start.
- Base=24, ready=1 -> coef_data 25..32 then 1..8 (wrap); coef_last on value 8.
- Ready toggled 1,0,0,1,... -> each word is held stable while ready is low; no loss or duplication; the sequence still reads 1..16.
- start while busy -> start_err=1 for one cycle, burst unaffected. Drop cs for 3 cycles mid-burst -> valid drops, then the stream resumes at the next tap. rst_n low mid-burst -> outputs zero immediately.
- With FIR_COEF_SYMMETRIC_EN defined, base=0, same memory contents -> 1..8 then 8..1.
